cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss-handling stage directly downstream of the 4-way set-associative tag lookup. Accepts one
//  load/store miss at a time, issues a line-aligned read to memory, streams returned beats into the
//  victim way, and pulses completion so the lookup stage can set the valid bit and retry.
//  Single outstanding miss (blocking cache); write-allocate for store misses.
// PARAMETERS
//  ADDR_W   32  byte address width
//  DATA_W   32  memory beat / cache word width
//  INDEX_W  14  set index bits
//  WAYS     4   associativity; WAY_W = $clog2(WAYS)
//  BEATS    4   words per line; BEAT_W = $clog2(BEATS), OFF_W = BEAT_W+2
//  TAG_W = ADDR_W-INDEX_W-OFF_W (localparam, 14 with defaults)
// PORTS
//  clk            in   1        clock, all state on posedge
//  rst_n          in   1        asynchronous active-low reset
//  miss_valid     in   1        lookup presents a miss
//  miss_ready     out  1        controller can accept a miss
//  miss_addr      in   ADDR_W   missing byte address
//  miss_is_store  in   1        1 = store miss, 0 = load miss
//  miss_way       in   WAY_W    victim way chosen by lookup
//  mem_req_valid  out  1        line read request
//  mem_req_ready  in   1        memory accepts request
//  mem_req_addr   out  ADDR_W   miss_addr with low OFF_W bits zeroed
//  mem_rsp_valid  in   1        response beat valid (no backpressure)
//  mem_rsp_data   in   DATA_W   response beat
//  mem_rsp_last   in   1        final beat of line
//  fill_valid     out  1        write fill_data into the data array this cycle
//  fill_index     out  INDEX_W  set being filled
//  fill_way       out  WAY_W    way being filled
//  fill_beat      out  BEAT_W   word within line
//  fill_data      out  DATA_W   word to write
//  fill_done      out  1        1-cycle pulse: write fill_tag, set valid, retry access
//  fill_tag       out  TAG_W    tag for fill_done
//  fill_store     out  1        captured miss_is_store, valid with fill_done
//  busy           out  1        state != IDLE
//  refill_cnt     out  32       completed refills, saturates at 32'hFFFF_FFFF
//  proto_err      out  1        sticky protocol-error flag
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; every output 0; counters, captured fields 0.
//  - FSM IDLE -> REQ -> RESP -> DONE -> IDLE.
//    IDLE: miss_ready=1; miss_valid&miss_ready captures addr/is_store/way, goes REQ next cycle.
//    REQ:  mem_req_valid=1, addr held stable until mem_req_ready; handshake -> RESP, beat=0.
//    RESP: each mem_rsp_valid -> fill_valid same cycle (combinational pass-through of data),
//          fill_beat=beat, beat increments mod BEATS. Beat BEATS-1 -> DONE.
//    DONE: fill_done=1 for exactly one cycle, refill_cnt+1 (saturating); -> IDLE.
//  - Min latency miss accept -> fill_done: 2 + BEATS cycles with ready memory (6 with defaults).
//  - miss_ready is 0 in DONE; a miss presented during DONE is accepted next cycle in IDLE.
//  - mem_rsp_last on beat != BEATS-1, or absent on beat BEATS-1: set proto_err; line still
//    completes on beat count (last is advisory). mem_rsp_valid outside RESP: ignored, proto_err=1.
//  - proto_err clears only on reset. refill_cnt never wraps.
//  - Reset mid-RESP: fill_valid drops asynchronously, no fill_done; partial line stays invalid.
// STRUCTURE
//  - cache_pkg: INDEX_W/WAYS/BEATS defaults, state enum {IDLE,REQ,RESP,DONE}, addr field
//    slicing functions (get_index, get_tag, line_align) shared with the tag-lookup stage.
//  - No sub-module; one FSM block, one capture register set, beat counter, stats counter.
// TESTING
//  - Load miss addr 32'h1234_5678, way 2, mem ready, 4 beats A0..A3 -> mem_req_addr 32'h1234_5670,
//    fill_index 14'h0567, beats 0..3 data A0..A3, fill_done at cycle 6, fill_tag 14'h048D, fill_store 0.
//  - mem_req_ready held 0 for 5 cycles -> mem_req_valid/addr stable, no fill, busy=1 throughout.
//  - Back-to-back misses, 2nd miss_valid held during DONE -> accepted first IDLE cycle, refill_cnt=2.
//  - mem_rsp_last on beat 1 -> proto_err=1, refill still completes after 4 beats.
//  - Assert rst_n=0 during beat 2 -> outputs 0 immediately, no fill_done, refill_cnt=0, IDLE.
//  - Preload refill_cnt 32'hFFFF_FFFF (force), complete refill -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared definitions for the cache miss path: default geometry, the refill
//   FSM state encoding and address field slicing helpers used by both the tag
//   lookup stage and the refill controller.
//   No ports (package).
package cache_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_INDEX_W = 14;
    localparam int DEF_WAYS    = 4;
    localparam int DEF_BEATS   = 4;

    localparam int DEF_WAY_W  = $clog2(DEF_WAYS);
    localparam int DEF_BEAT_W = $clog2(DEF_BEATS);
    localparam int DEF_OFF_W  = DEF_BEAT_W + 2;
    localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_INDEX_W - DEF_OFF_W;

    // Refill FSM encoding, kept as plain constants so older tools and
    // waveform scripts that decode the raw 2-bit value keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [DEF_INDEX_W-1:0] get_index(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_OFF_W +: DEF_INDEX_W];
    endfunction

    function automatic logic [DEF_TAG_W-1:0] get_tag(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_ADDR_W-1 -: DEF_TAG_W];
    endfunction

    function automatic logic [DEF_ADDR_W-1:0] line_align(input logic [DEF_ADDR_W-1:0] addr);
        return {addr[DEF_ADDR_W-1:DEF_OFF_W], {DEF_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Blocking-cache miss handler sitting behind the tag lookup. Takes one miss
//   at a time, issues a line-aligned read to memory, forwards each returned
//   beat straight into the victim way of the data array and then pulses
//   fill_done so the lookup stage can write the tag, set valid and retry.
//   Store misses are handled as write-allocate (same refill, flag passed on).
// Ports
//   clk, rst_n                     clock, async active-low reset
//   miss_valid/ready/addr/
//   miss_is_store/miss_way         miss request from lookup
//   mem_req_valid/ready/addr       line read request to memory
//   mem_rsp_valid/data/last        returned beats (no backpressure)
//   fill_valid/index/way/beat/data data array write port
//   fill_done/tag/store            line complete notification
//   busy                           controller not idle
//   refill_cnt                     saturating count of completed refills
//   proto_err                      sticky memory protocol error
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WAYS    = DEF_WAYS,
    parameter int BEATS   = DEF_BEATS,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int BEAT_W = $clog2(BEATS),
    localparam int OFF_W  = BEAT_W + 2,
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic [ADDR_W-1:0]  miss_addr,
    input  logic               miss_is_store,
    input  logic [WAY_W-1:0]   miss_way,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [DATA_W-1:0]  mem_rsp_data,
    input  logic               mem_rsp_last,
    output logic               fill_valid,
    output logic [INDEX_W-1:0] fill_index,
    output logic [WAY_W-1:0]   fill_way,
    output logic [BEAT_W-1:0]  fill_beat,
    output logic [DATA_W-1:0]  fill_data,
    output logic               fill_done,
    output logic [TAG_W-1:0]   fill_tag,
    output logic               fill_store,
    output logic               busy,
    output logic [31:0]        refill_cnt,
    output logic               proto_err
);

    logic [1:0]              state_q;
    logic [ADDR_W-OFF_W-1:0] line_q;
    logic                    store_q;
    logic [WAY_W-1:0]        way_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [31:0]             cnt_q;
    logic                    err_q;

    logic accept;
    logic rsp_fire;
    logic last_beat;
    logic unused_offset;

    assign accept    = miss_valid && (state_q == ST_IDLE);
    assign rsp_fire  = mem_rsp_valid && (state_q == ST_RESP);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // Byte offset within the line is irrelevant: the whole line is refilled.
    assign unused_offset = ^miss_addr[OFF_W-1:0];

    // Main sequencer. Line completion is decided purely by beat count;
    // mem_rsp_last is only cross-checked for the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept)                state_q <= ST_REQ;
                ST_REQ:  if (mem_req_ready)         state_q <= ST_RESP;
                ST_RESP: if (rsp_fire && last_beat) state_q <= ST_DONE;
                ST_DONE:                            state_q <= ST_IDLE;
                default:                            state_q <= ST_IDLE;
            endcase
        end
    end

    // Miss fields are held for the whole refill so request address, fill
    // index and tag stay stable regardless of what lookup drives meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '0;
            store_q <= 1'b0;
            way_q   <= '0;
        end else if (accept) begin
            line_q  <= miss_addr[ADDR_W-1:OFF_W];
            store_q <= miss_is_store;
            way_q   <= miss_way;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if ((state_q == ST_REQ) && mem_req_ready) begin
            beat_q <= '0;
        end else if (rsp_fire) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_q == ST_DONE) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Sticky: a stray beat outside RESP, or a last flag that disagrees with
    // the beat count, both indicate a misbehaving memory side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((mem_rsp_valid && (state_q != ST_RESP)) ||
                     (rsp_fire && (mem_rsp_last != last_beat))) begin
            err_q <= 1'b1;
        end
    end

    assign miss_ready    = (state_q == ST_IDLE) && rst_n;
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = {line_q, {OFF_W{1'b0}}};
    assign fill_valid    = rsp_fire;
    assign fill_index    = line_q[INDEX_W-1:0];
    assign fill_way      = way_q;
    assign fill_beat     = beat_q;
    assign fill_data     = rsp_fire ? mem_rsp_data : '0;
    assign fill_done     = (state_q == ST_DONE);
    assign fill_tag      = line_q[ADDR_W-OFF_W-1 -: TAG_W];
    assign fill_store    = store_q;
    assign busy          = (state_q != ST_IDLE);
    assign refill_cnt    = cnt_q;
    assign proto_err     = err_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl
//   Drives directed and randomized misses through cache_refill_ctrl and
//   compares against a transaction-level reference: expected address fields
//   come from plain arithmetic on the miss address, expected beats from the
//   data the bench itself returns, and the refill count / error flag from a
//   small model updated once per transaction.
module tb_cache_refill_ctrl;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [31:0] miss_addr = '0;
    logic        miss_is_store = 1'b0;
    logic [1:0]  miss_way = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_last = 1'b0;
    logic        fill_valid;
    logic [13:0] fill_index;
    logic [1:0]  fill_way;
    logic [1:0]  fill_beat;
    logic [31:0] fill_data;
    logic        fill_done;
    logic [13:0] fill_tag;
    logic        fill_store;
    logic        busy;
    logic [31:0] refill_cnt;
    logic        proto_err;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] modelCnt = '0;
    bit          modelErr = 1'b0;

    cache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_is_store(miss_is_store), .miss_way(miss_way),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
        .fill_beat(fill_beat), .fill_data(fill_data), .fill_done(fill_done),
        .fill_tag(fill_tag), .fill_store(fill_store), .busy(busy),
        .refill_cnt(refill_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Safety net in case the design stops responding altogether.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One complete miss. lastBeat is the beat carrying mem_rsp_last (3 is
    // legal); abortBeat >= 0 pulls reset while that beat is on the bus;
    // backToBack returns while fill_done is still high so the next call
    // presents its miss during the completion cycle.
    task automatic applyStimulus(input logic [31:0] addr, input bit store, input logic [1:0] way,
                                 input int reqDelay, input int lastBeat, input int gapMax,
                                 input int abortBeat, input bit backToBack,
                                 input logic [31:0] dataBase, input bit randData,
                                 input bit checkLatency);
        logic [31:0] expAlign;
        logic [13:0] expIndex;
        logic [13:0] expTag;
        logic [31:0] beatData;
        int waits;
        int edges;
        int gaps;
        bit wasDone;
        expAlign = addr - (addr % 32'd16);
        expIndex = 14'((addr / 32'd16) % 32'd16384);
        expTag   = 14'(addr / 32'd262144);
        wasDone  = (fill_done === 1'b1);

        miss_valid = 1'b1; miss_addr = addr; miss_is_store = store; miss_way = way;
        waits = 0;
        while (miss_ready !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
        if (miss_ready !== 1'b1) begin
            checkOutput("missAcceptTimeout", 64'(miss_ready), 64'(1));
            miss_valid = 1'b0;
            return;
        end
        if (wasDone) checkOutput("b2bAcceptWait", 64'(waits), 64'(1));
        checkOutput("cntAtAccept", 64'(refill_cnt), 64'(modelCnt));
        checkOutput("errAtAccept", 64'(proto_err), 64'(modelErr));

        tick();
        edges = 1;
        miss_valid = 1'b0; miss_addr = $urandom; miss_way = 2'($urandom_range(3, 0));
        checkOutput("reqValid", 64'(mem_req_valid), 64'(1));
        checkOutput("reqAddr", 64'(mem_req_addr), 64'(expAlign));
        checkOutput("busyReq", 64'(busy), 64'(1));
        checkOutput("missReadyReq", 64'(miss_ready), 64'(0));

        for (int i = 0; i < reqDelay; i++) begin
            tick();
            edges++;
            checkOutput("reqHold", 64'(mem_req_valid), 64'(1));
            checkOutput("reqAddrHold", 64'(mem_req_addr), 64'(expAlign));
            checkOutput("noFillStall", 64'(fill_valid), 64'(0));
            checkOutput("busyStall", 64'(busy), 64'(1));
        end
        mem_req_ready = 1'b1;
        tick();
        edges++;
        mem_req_ready = 1'b0;
        checkOutput("reqDropped", 64'(mem_req_valid), 64'(0));

        for (int b = 0; b < BEATS; b++) begin
            gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                #1;
                checkOutput("noFillGap", 64'(fill_valid), 64'(0));
                tick();
                edges++;
            end
            beatData = randData ? $urandom : 32'(dataBase + 32'(b));
            mem_rsp_valid = 1'b1; mem_rsp_data = beatData; mem_rsp_last = (b == lastBeat);
            #1;
            checkOutput("fillValid", 64'(fill_valid), 64'(1));
            checkOutput("fillBeat", 64'(fill_beat), 64'(b));
            checkOutput("fillData", 64'(fill_data), 64'(beatData));
            checkOutput("fillWay", 64'(fill_way), 64'(way));
            checkOutput("fillIndex", 64'(fill_index), 64'(expIndex));
            checkOutput("noEarlyDone", 64'(fill_done), 64'(0));
            if (b == abortBeat) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rstFillValid", 64'(fill_valid), 64'(0));
                checkOutput("rstFillData", 64'(fill_data), 64'(0));
                checkOutput("rstFillDone", 64'(fill_done), 64'(0));
                checkOutput("rstBusy", 64'(busy), 64'(0));
                checkOutput("rstReqValid", 64'(mem_req_valid), 64'(0));
                checkOutput("rstMissReady", 64'(miss_ready), 64'(0));
                checkOutput("rstCnt", 64'(refill_cnt), 64'(0));
                mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
                modelCnt = '0; modelErr = 1'b0;
                tick();
                checkOutput("rstNoDone", 64'(fill_done), 64'(0));
                rst_n = 1'b1;
                tick();
                checkOutput("idleAfterRst", 64'(miss_ready), 64'(1));
                checkOutput("errAfterRst", 64'(proto_err), 64'(0));
                return;
            end
            if ((b == lastBeat) != (b == BEATS - 1)) modelErr = 1'b1;
            tick();
            edges++;
            mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
        end

        checkOutput("fillDone", 64'(fill_done), 64'(1));
        checkOutput("fillTag", 64'(fill_tag), 64'(expTag));
        checkOutput("fillStore", 64'(fill_store), 64'(store));
        checkOutput("doneWay", 64'(fill_way), 64'(way));
        checkOutput("doneNoFill", 64'(fill_valid), 64'(0));
        checkOutput("missReadyDone", 64'(miss_ready), 64'(0));
        checkOutput("protoErr", 64'(proto_err), 64'(modelErr));
        if (checkLatency) checkOutput("latency", 64'(edges), 64'(2 + BEATS));
        modelCnt = satInc(modelCnt);

        if (!backToBack) begin
            tick();
            checkOutput("donePulse", 64'(fill_done), 64'(0));
            checkOutput("idleBusy", 64'(busy), 64'(0));
            checkOutput("idleReady", 64'(miss_ready), 64'(1));
            checkOutput("cntAfter", 64'(refill_cnt), 64'(modelCnt));
        end
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReady", 64'(miss_ready), 64'(0));
        checkOutput("rstBusy0", 64'(busy), 64'(0));
        checkOutput("rstReq", 64'(mem_req_valid), 64'(0));
        checkOutput("rstReqAddr", 64'(mem_req_addr), 64'(0));
        checkOutput("rstDone", 64'(fill_done), 64'(0));
        checkOutput("rstTag", 64'(fill_tag), 64'(0));
        checkOutput("rstCnt0", 64'(refill_cnt), 64'(0));
        checkOutput("rstErr", 64'(proto_err), 64'(0));
        rst_n = 1'b1;
        tick();

        // Load miss with ready memory, A0..A3, next miss held through DONE.
        applyStimulus(32'h1234_5678, 1'b0, 2'd2, 0, 3, 0, -1, 1'b1, 32'hA0, 1'b0, 1'b1);
        // Second miss (store) with request stalled 5 cycles.
        applyStimulus(32'hCAFE_0010, 1'b1, 2'd1, 5, 3, 0, -1, 1'b0, 32'hB0, 1'b0, 1'b0);
        checkOutput("cntTwo", 64'(refill_cnt), 64'(2));
        checkOutput("errClean", 64'(proto_err), 64'(0));

        // Early last flag on beat 1: error, but line still takes 4 beats.
        applyStimulus(32'h0000_ABC4, 1'b0, 2'd3, 0, 1, 0, -1, 1'b0, 32'hC0, 1'b0, 1'b1);
        checkOutput("errSticky", 64'(proto_err), 64'(1));

        // Reset while beat 2 is on the bus.
        applyStimulus(32'h8765_4321, 1'b1, 2'd0, 1, 3, 0, 2, 1'b0, 32'hD0, 1'b0, 1'b0);

        // Stray response beat while idle.
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        #1;
        checkOutput("strayNoFill", 64'(fill_valid), 64'(0));
        tick();
        mem_rsp_valid = 1'b0;
        modelErr = 1'b1;
        checkOutput("strayErr", 64'(proto_err), 64'(1));

        for (int i = 0; i < 12; i++) begin
            applyStimulus($urandom, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                          int'($urandom_range(3, 0)),
                          ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : 3,
                          2, -1, (i < 11) ? 1'($urandom_range(1, 0)) : 1'b0,
                          32'h0, 1'b1, 1'b0);
        end

        // Counter saturation.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        modelCnt = 32'hFFFF_FFFF;
        applyStimulus(32'h0F0F_F0F0, 1'b0, 2'd1, 0, 3, 0, -1, 1'b0, 32'hE0, 1'b0, 1'b0);
        checkOutput("cntSaturated", 64'(refill_cnt), 64'(32'hFFFF_FFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
